// File: rtl/seg_scan_adder_pkg.sv
// Shared constants for the multiplexed 7-segment adder/display.
package seg_scan_adder_pkg;

    // All segments dark (active-low bus)
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Hex glyphs, active-low, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] GLYPH_0 = 7'h40;
    localparam logic [6:0] GLYPH_1 = 7'h79;
    localparam logic [6:0] GLYPH_2 = 7'h24;
    localparam logic [6:0] GLYPH_3 = 7'h30;
    localparam logic [6:0] GLYPH_4 = 7'h19;
    localparam logic [6:0] GLYPH_5 = 7'h12;
    localparam logic [6:0] GLYPH_6 = 7'h02;
    localparam logic [6:0] GLYPH_7 = 7'h78;
    localparam logic [6:0] GLYPH_8 = 7'h00;
    localparam logic [6:0] GLYPH_9 = 7'h10;
    localparam logic [6:0] GLYPH_A = 7'h08;
    localparam logic [6:0] GLYPH_B = 7'h03;
    localparam logic [6:0] GLYPH_C = 7'h46;
    localparam logic [6:0] GLYPH_D = 7'h21;
    localparam logic [6:0] GLYPH_E = 7'h06;
    localparam logic [6:0] GLYPH_F = 7'h0E;

    // Bits needed to hold 0..v-1; never less than one bit
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/seg_scan_adder_decode.sv
// Combinational nibble to active-low hex glyph decoder.
module seven_seg_decode
    import seg_scan_adder_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] glyph_c
);

    // Glyph lookup
    always_comb begin
        glyph_c = SEG_OFF;
        case (nib)
            4'h0: glyph_c = GLYPH_0;
            4'h1: glyph_c = GLYPH_1;
            4'h2: glyph_c = GLYPH_2;
            4'h3: glyph_c = GLYPH_3;
            4'h4: glyph_c = GLYPH_4;
            4'h5: glyph_c = GLYPH_5;
            4'h6: glyph_c = GLYPH_6;
            4'h7: glyph_c = GLYPH_7;
            4'h8: glyph_c = GLYPH_8;
            4'h9: glyph_c = GLYPH_9;
            4'hA: glyph_c = GLYPH_A;
            4'hB: glyph_c = GLYPH_B;
            4'hC: glyph_c = GLYPH_C;
            4'hD: glyph_c = GLYPH_D;
            4'hE: glyph_c = GLYPH_E;
            4'hF: glyph_c = GLYPH_F;
            default: glyph_c = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg_scan_adder.sv
// Adds or passes two operands into a captured result and scans it onto a
// time-multiplexed common-anode 7-segment bank.
module seg_scan_adder
    import seg_scan_adder_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned SCAN_DIV = 50000,
    parameter int unsigned BLANK_LZ = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  din_a,
    input  logic [WIDTH-1:0]  din_b,
    input  logic              sel,
    input  logic              load,
    output logic [6:0]        seg,
    output logic              dp,
    output logic [DIGITS-1:0] an
);

    localparam int unsigned RES_W = 4 * DIGITS;
    localparam int unsigned SUM_W = WIDTH + 1;
    localparam int unsigned CNT_W = clog2(SCAN_DIV);
    localparam int unsigned IDX_W = clog2(DIGITS);

    if (RES_W < 2 * WIDTH) begin : g_width_check
        $error("seg_scan_adder: 4*DIGITS must be >= 2*WIDTH");
    end

    logic [RES_W-1:0]  result_q;
    logic              carry_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [IDX_W-1:0]  idx_q;
    logic              active_q;
    logic              tick;
    logic [SUM_W-1:0]  sum;
    logic [RES_W-1:0]  shifted;
    logic              blank;
    logic [6:0]        glyph;
    logic [DIGITS-1:0] an_d;
    logic              dp_d;

    assign sum  = SUM_W'(din_a) + SUM_W'(din_b);
    assign tick = (cnt_q == CNT_W'(SCAN_DIV - 1));

    // Capture the selected value; only a load strobe changes what is shown
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
            carry_q  <= 1'b0;
        end else if (load) begin
            result_q <= sel ? RES_W'({din_a, din_b}) : RES_W'(sum);
            carry_q  <= ~sel & sum[WIDTH];
        end
    end

    // Slot prescaler
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= tick ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Digit index; the first tick after reset only lights the bank
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q    <= '0;
            active_q <= 1'b0;
        end else if (tick) begin
            if (!active_q) begin
                active_q <= 1'b1;
            end else begin
                idx_q <= (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
            end
        end
    end

    // Nibble select, leading-zero blanking, anode and decimal point for the current slot
    always_comb begin
        shifted = result_q >> {idx_q, 2'b00};
        blank   = (BLANK_LZ != 0) && (idx_q != '0) && (shifted == '0);
        an_d    = ~(DIGITS'(1) << idx_q);
        dp_d    = ~(carry_q && (idx_q == '0));
    end

    seven_seg_decode u_decode (
        .nib     (shifted[3:0]),
        .glyph_c (glyph)
    );

    // Output registers: anode, segments and dp always move together
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg <= SEG_OFF;
            dp  <= 1'b1;
            an  <= '1;
        end else if (!active_q) begin
            seg <= SEG_OFF;
            dp  <= 1'b1;
            an  <= '1;
        end else begin
            seg <= blank ? SEG_OFF : glyph;
            dp  <= dp_d;
            an  <= an_d;
        end
    end

endmodule

// File: tb/tb_seg_scan_adder.sv
// Randomized bench for seg_scan_adder with an edge-count based reference model.
module tb_seg_scan_adder;

    localparam int W = 4;
    localparam int D = 4;
    localparam int S = 4;
    localparam int PERIOD2 = 2 * S * D;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         sel = 1'b0;
    logic         load = 1'b0;
    logic [6:0]   seg, seg_nb;
    logic         dp, dp_nb;
    logic [D-1:0] an, an_nb;

    int n_cmp = 0;
    int n_err = 0;

    // Model state: edges since reset release, captured value and carry flag
    int          n = 0;
    int unsigned val = 0;
    bit          carry = 1'b0;
    logic [6:0]  stream_a [PERIOD2];

    seg_scan_adder #(.WIDTH(W), .DIGITS(D), .SCAN_DIV(S), .BLANK_LZ(1)) dut (
        .clk(clk), .rst(rst), .din_a(a), .din_b(b), .sel(sel), .load(load),
        .seg(seg), .dp(dp), .an(an)
    );

    seg_scan_adder #(.WIDTH(W), .DIGITS(D), .SCAN_DIV(S), .BLANK_LZ(0)) dut_nb (
        .clk(clk), .rst(rst), .din_a(a), .din_b(b), .sel(sel), .load(load),
        .seg(seg_nb), .dp(dp_nb), .an(an_nb)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", tag, got, exp, n, $time);
        end
    endtask

    // Standard hex glyphs as lit-segment sets, inverted for the active-low bus
    function automatic logic [6:0] ref_glyph(input int nib);
        logic [6:0] lit;
        case (nib)
            0: lit = 7'h3F;  1: lit = 7'h06;  2: lit = 7'h5B;  3: lit = 7'h4F;
            4: lit = 7'h66;  5: lit = 7'h6D;  6: lit = 7'h7D;  7: lit = 7'h07;
            8: lit = 7'h7F;  9: lit = 7'h6F; 10: lit = 7'h77; 11: lit = 7'h7C;
            12: lit = 7'h39; 13: lit = 7'h5E; 14: lit = 7'h79; default: lit = 7'h71;
        endcase
        return ~lit;
    endfunction

    // One clock: predict outputs from the state before this edge, then apply a load
    task automatic step(input bit ld);
        int          m, k, idx;
        int unsigned part;
        bit          dark;
        logic [3:0]  e_an;
        logic [6:0]  e_seg, e_seg_nb;
        logic        e_dp;
        load = ld;
        @(posedge clk);
        m = n;
        n++;
        k = m / S;
        dark = (k == 0);
        idx = dark ? 0 : (k - 1) % D;
        part = val >> (4 * idx);
        if (dark) begin
            e_an = 4'hF; e_seg = 7'h7F; e_seg_nb = 7'h7F; e_dp = 1'b1;
        end else begin
            e_an     = 4'hF & ~(4'h1 << idx);
            e_seg_nb = ref_glyph(int'(part % 16));
            e_seg    = (idx > 0 && part == 0) ? 7'h7F : e_seg_nb;
            e_dp     = !(idx == 0 && carry);
        end
        if (ld) begin
            if (sel) begin
                val = int'(a) * 16 + int'(b);
                carry = 1'b0;
            end else begin
                val = int'(a) + int'(b);
                carry = (val > 15);
            end
        end
        #1;
        check("an", 32'(an), 32'(e_an));
        check("seg", 32'(seg), 32'(e_seg));
        check("dp", 32'(dp), 32'(e_dp));
        check("an_nb", 32'(an_nb), 32'(e_an));
        check("seg_nb", 32'(seg_nb), 32'(e_seg_nb));
        check("dp_nb", 32'(dp_nb), 32'(e_dp));
        if (!dark) check("an_onehot", 32'($onehot(~an)), 32'd1);
        load = 1'b0;
    endtask

    // Reset asserted between clock edges; outputs must go dark without an edge
    task automatic do_reset();
        #3;
        rst = 1'b1;
        #1;
        check("rst_an", 32'(an), 32'hF);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_dp", 32'(dp), 32'd1);
        check("rst_seg_nb", 32'(seg_nb), 32'h7F);
        val = 0;
        carry = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        n = 0;
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0);
    endtask

    task automatic load_value(input logic [3:0] va, input logic [3:0] vb, input logic vs);
        a = va; b = vb; sel = vs;
        step(1'b1);
    endtask

    initial begin
        do_reset();
        run(S + 2);
        check("first_tick_an", 32'(an), 32'hE);

        // 9 + 8 = 0x11 with carry on digit 0
        load_value(4'h9, 4'h8, 1'b0);
        run(PERIOD2);

        // raw {A,5}
        load_value(4'hA, 4'h5, 1'b1);
        run(PERIOD2);

        // operand changes without load leave the stream untouched
        for (int i = 0; i < PERIOD2; i++) begin
            step(1'b0);
            stream_a[i] = seg;
        end
        a = 4'h3; b = 4'hC; sel = 1'b0;
        for (int i = 0; i < PERIOD2; i++) begin
            step(1'b0);
            check("stream", 32'(seg), 32'(stream_a[i]));
        end

        // all zeros
        load_value(4'h0, 4'h0, 1'b0);
        run(PERIOD2);

        // load coinciding with a slot tick
        load_value(4'hF, 4'hF, 1'b0);
        run(S + 1);
        a = 4'h3; b = 4'hC; sel = 1'b1;
        while (((n + 1) % S) != 0) step(1'b0);
        step(1'b1);
        run(PERIOD2);
        a = 4'h7; b = 4'h9; sel = 1'b0;
        while (((n + 1) % S) != 0) step(1'b0);
        step(1'b1);
        run(PERIOD2);

        // reset mid-scan drops the captured value
        do_reset();
        run(PERIOD2);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            a   = 4'($urandom_range(0, 15));
            b   = 4'($urandom_range(0, 15));
            sel = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 299) == 0) do_reset();
            step($urandom_range(0, 7) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
